// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Purpose  : Sequencer for the 4x4 systolic multiplier array. It collects
//            A and B (32 bytes, row-major) from the UART receiver while the
//            array is held in reset. It then drives the skewed row/column
//            wavefront, waits for the array's done flag, and captures
//            C0..C15. The results go back out to the UART transmitter,
//            high byte first.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            rx_data/valid/ready   - byte stream in (accepted only in LOAD)
//            tx_data/valid/ready   - result byte stream out
//            arr_rst               - reset to the array (high in LOAD)
//            A0..A3 / B0..B3       - row / column operands to the array
//            arr_done, C0..C15     - array completion flag and results
//            busy, err             - not-in-LOAD flag, sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int REG_WIDTH = 8,
    parameter int OUT_WIDTH = REG_WIDTH * 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 arr_rst,
    output logic [REG_WIDTH-1:0] A0, A1, A2, A3,
    output logic [REG_WIDTH-1:0] B0, B1, B2, B3,
    input  logic                 arr_done,
    input  logic [OUT_WIDTH-1:0] C0, C1, C2, C3, C4, C5, C6, C7,
    input  logic [OUT_WIDTH-1:0] C8, C9, C10, C11, C12, C13, C14, C15,
    output logic                 busy,
    output logic                 err
);

    localparam logic [1:0] c_st_load = 2'd0;
    localparam logic [1:0] c_st_feed = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_send = 2'd3;

    localparam int                  c_wcnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(TIMEOUT - 1);

    logic [1:0]           r_state, w_state_nxt;
    logic [4:0]           r_idx;       // RX byte index
    logic [2:0]           r_k;         // wavefront step in FEED
    logic [c_wcnt_w-1:0]  r_wcnt;      // cycles spent in WAIT
    logic [4:0]           r_sidx;      // TX byte index
    logic [REG_WIDTH-1:0] r_buf [0:31];
    logic [OUT_WIDTH-1:0] r_res [0:15];
    logic [OUT_WIDTH-1:0] w_c   [0:15];

    logic                 w_rx_fire, w_tx_fire, w_timeout;
    logic                 w_feed_en;
    logic [2:0]           w_fk;
    logic [REG_WIDTH-1:0] w_a [0:3];
    logic [REG_WIDTH-1:0] w_b [0:3];
    logic [4:0]           w_sel_idx;
    logic [7:0]           w_tx_byte;

    assign w_c[0]  = C0;  assign w_c[1]  = C1;  assign w_c[2]  = C2;  assign w_c[3]  = C3;
    assign w_c[4]  = C4;  assign w_c[5]  = C5;  assign w_c[6]  = C6;  assign w_c[7]  = C7;
    assign w_c[8]  = C8;  assign w_c[9]  = C9;  assign w_c[10] = C10; assign w_c[11] = C11;
    assign w_c[12] = C12; assign w_c[13] = C13; assign w_c[14] = C14; assign w_c[15] = C15;

    assign w_rx_fire = rx_valid && (r_state == c_st_load);
    assign w_tx_fire = tx_valid && tx_ready && (r_state == c_st_send);
    assign w_timeout = (r_state == c_st_wait) && !arr_done && (r_wcnt == c_wcnt_last);

    // Operand registers are loaded with the step about to be shown, so the
    // first wavefront appears the cycle after the last byte is accepted.
    assign w_feed_en = (w_rx_fire && (r_idx == 5'd31)) ||
                       ((r_state == c_st_feed) && (r_k != 3'd6));
    assign w_fk      = (r_state == c_st_feed) ? 3'(r_k + 3'd1) : 3'd0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [2:0] d;
            d      = 3'(w_fk - 3'(i));
            w_a[i] = '0;
            w_b[i] = '0;
            if (w_feed_en && (w_fk >= 3'(i)) && (d <= 3'd3)) begin
                w_a[i] = r_buf[5'(5'(4 * i) + 5'(d))];
                w_b[i] = r_buf[5'(5'd16 + {d[1:0], 2'b00} + 5'(i))];
            end
        end
    end

    // Next TX byte: even index = high byte of element idx/2, odd = low byte.
    assign w_sel_idx = 5'(r_sidx + 5'd1);
    assign w_tx_byte = w_sel_idx[0] ? r_res[w_sel_idx[4:1]][0 +: 8]
                                    : r_res[w_sel_idx[4:1]][REG_WIDTH +: 8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_load: if (w_rx_fire && (r_idx == 5'd31)) w_state_nxt = c_st_feed;
            c_st_feed: if (r_k == 3'd6)                    w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (arr_done)       w_state_nxt = c_st_send;
                else if (w_timeout) w_state_nxt = c_st_load;
            end
            default:   if (w_tx_fire && (r_sidx == 5'd31)) w_state_nxt = c_st_load;
        endcase
    end

    // Operand and result storage carry no reset: the byte index restarting
    // at 0 guarantees every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (!reset && w_rx_fire) r_buf[r_idx] <= rx_data[REG_WIDTH-1:0];
        if (!reset && (r_state == c_st_wait) && arr_done) r_res <= w_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_load;
            r_idx    <= '0;
            r_k      <= '0;
            r_wcnt   <= '0;
            r_sidx   <= '0;
            err      <= 1'b0;
            arr_rst  <= 1'b1;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            A0 <= '0; A1 <= '0; A2 <= '0; A3 <= '0;
            B0 <= '0; B1 <= '0; B2 <= '0; B3 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            arr_rst  <= (w_state_nxt == c_st_load);
            rx_ready <= (w_state_nxt == c_st_load);
            busy     <= (w_state_nxt != c_st_load);
            A0 <= w_a[0]; A1 <= w_a[1]; A2 <= w_a[2]; A3 <= w_a[3];
            B0 <= w_b[0]; B1 <= w_b[1]; B2 <= w_b[2]; B3 <= w_b[3];
            case (r_state)
                c_st_load: begin
                    if (w_rx_fire) begin
                        r_idx <= 5'(r_idx + 5'd1);
                        r_k   <= 3'd0;
                    end
                end
                c_st_feed: begin
                    r_k    <= 3'(r_k + 3'd1);
                    r_wcnt <= '0;
                end
                c_st_wait: begin
                    if (arr_done) begin
                        r_sidx   <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= w_c[0][REG_WIDTH +: 8];
                    end else if (w_timeout) begin
                        err   <= 1'b1;
                        r_idx <= '0;
                    end else begin
                        r_wcnt <= c_wcnt_w'(r_wcnt + 1'b1);
                    end
                end
                default: begin
                    if (w_tx_fire) begin
                        if (r_sidx == 5'd31) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            r_idx    <= '0;
                        end else begin
                            r_sidx  <= w_sel_idx;
                            tx_data <= w_tx_byte;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq_ctrl
// Purpose  : Directed self-checking bench for systolic_seq_ctrl. It includes
//            a behavioural array model that accumulates the captured
//            wavefront the way the 4x4 PE grid would.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        arr_rst, arr_done, busy, err;
    logic [7:0]  A0, A1, A2, A3, B0, B1, B2, B3;
    logic [15:0] c [16];

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  ma [16];
    logic [7:0]  mb [16];
    logic [15:0] exp_c [16];
    logic [7:0]  exp_tx [32];
    logic [7:0]  fa [7][4];
    logic [7:0]  fb [7][4];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.REG_WIDTH(8), .OUT_WIDTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .arr_rst(arr_rst),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3),
        .arr_done(arr_done),
        .C0(c[0]),   .C1(c[1]),   .C2(c[2]),   .C3(c[3]),
        .C4(c[4]),   .C5(c[5]),   .C6(c[6]),   .C7(c[7]),
        .C8(c[8]),   .C9(c[9]),   .C10(c[10]), .C11(c[11]),
        .C12(c[12]), .C13(c[13]), .C14(c[14]), .C15(c[15]),
        .busy(busy), .err(err)
    );

    function automatic logic [63:0] exp_feed(input int k);
        logic [7:0] a [4];
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'h00;
            b[i] = 8'h00;
            if (k - i >= 0 && k - i <= 3) begin
                a[i] = ma[4 * i + k - i];
                b[i] = mb[4 * (k - i) + i];
            end
        end
        return {a[0], a[1], a[2], a[3], b[0], b[1], b[2], b[3]};
    endfunction

    task automatic ref_matmul();
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++) begin
                logic [15:0] s;
                s = 16'h0;
                for (int k = 0; k < 4; k++)
                    s = s + 16'(ma[4 * r + k]) * 16'(mb[4 * k + cc]);
                exp_c[4 * r + cc] = s;
            end
    endtask

    task automatic fill_exp_tx();
        for (int n = 0; n < 16; n++) begin
            exp_tx[2 * n]     = exp_c[n][15:8];
            exp_tx[2 * n + 1] = exp_c[n][7:0];
        end
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = (i < 16) ? ma[i] : mb[i - 16];
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    // Starts one cycle after the last byte; ends on the first WAIT cycle.
    task automatic capture_feed();
        for (int k = 0; k < 7; k++) begin
            fa[k][0] = A0; fa[k][1] = A1; fa[k][2] = A2; fa[k][3] = A3;
            fb[k][0] = B0; fb[k][1] = B1; fb[k][2] = B2; fb[k][3] = B3;
            n_vec++;
            if ({A0, A1, A2, A3, B0, B1, B2, B3} !== exp_feed(k)) begin
                n_bad++;
                $display("FAIL feed_k%0d got=%h want=%h", k,
                         {A0, A1, A2, A3, B0, B1, B2, B3}, exp_feed(k));
            end
            if (k == 0) begin
                n_vec++;
                if ({arr_rst, rx_ready, busy} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL feed_ctl got=%b want=001", {arr_rst, rx_ready, busy});
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if ({A0, A1, A2, A3, B0, B1, B2, B3} !== 64'h0) begin
            n_bad++;
            $display("FAIL feed_k7_zero got=%h want=0", {A0, A1, A2, A3, B0, B1, B2, B3});
        end
    endtask

    // Behavioural array: PE(i,j) pairs A[i][m] and B[m][j] at step m+i+j.
    task automatic array_respond(input int delay);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [15:0] s;
                s = 16'h0;
                for (int m = 0; m < 4; m++)
                    s = s + 16'(fa[m + i][i]) * 16'(fb[m + j][j]);
                c[4 * i + j] = s;
            end
        repeat (delay) @(negedge clk);
        arr_done = 1'b1;
        @(negedge clk);
        arr_done = 1'b0;
        n_vec++;
        if (tx_valid !== 1'b1 || tx_data !== exp_tx[0]) begin
            n_bad++;
            $display("FAIL done_to_tx valid=%b data=%h want valid=1 data=%h",
                     tx_valid, tx_data, exp_tx[0]);
        end
    endtask

    task automatic recv_tx(input bit stall, input bit poke);
        int         got;
        int         cyc;
        logic [7:0] held;
        bit         stalled;
        got = 0; cyc = 0; held = 8'h00; stalled = 1'b0;
        while (got < 32 && cyc < 400) begin
            tx_ready = stall ? (cyc % 3 == 2) : 1'b1;
            if (poke) begin
                rx_valid = 1'b1;
                rx_data  = 8'hEE;
            end
            if (tx_valid === 1'b1) begin
                if (stalled) begin
                    n_vec++;
                    if (tx_data !== held) begin
                        n_bad++;
                        $display("FAIL tx_hold byte%0d got=%h want=%h", got, tx_data, held);
                    end
                end
                if (poke) begin
                    n_vec++;
                    if (rx_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL rx_ready_in_send got=%b want=0", rx_ready);
                    end
                end
                if (tx_ready) begin
                    n_vec++;
                    if (tx_data !== exp_tx[got]) begin
                        n_bad++;
                        $display("FAIL tx_byte%0d got=%h want=%h", got, tx_data, exp_tx[got]);
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    held    = tx_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        n_vec++;
        if (got != 32) begin
            n_bad++;
            $display("FAIL tx_count got=%0d want=32", got);
        end
        n_vec++;
        if ({tx_valid, rx_ready, arr_rst, busy} !== 4'b0110) begin
            n_bad++;
            $display("FAIL after_send got=%b want=0110", {tx_valid, rx_ready, arr_rst, busy});
        end
    endtask

    task automatic run_op(input bit stall, input bit poke);
        send_bytes(32);
        capture_feed();
        array_respond(3);
        recv_tx(stall, poke);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({rx_ready, arr_rst, busy, err, tx_valid} !== 5'b11000 || tx_data !== 8'h00 ||
            {A0, A1, A2, A3, B0, B1, B2, B3} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_state got=%b tx=%h ab=%h want=11000 tx=00 ab=0",
                     {rx_ready, arr_rst, busy, err, tx_valid}, tx_data,
                     {A0, A1, A2, A3, B0, B1, B2, B3});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        for (int n = 0; n < 16; n++) begin
            ma[n]    = (n / 4 == n % 4) ? 8'h01 : 8'h00;
            mb[n]    = 8'(n + 1);
            exp_c[n] = 16'(n + 1);
        end
        fill_exp_tx();
        run_op(1'b0, 1'b0);
    endtask

    task automatic test_skew();
        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'(16 * (n / 4) + n % 4);
            mb[n] = 8'(8'h80 + n);
        end
        ref_matmul();
        fill_exp_tx();
        send_bytes(32);
        capture_feed();
        n_vec++;
        if ({fa[3][0], fa[3][1], fa[3][2], fa[3][3]} !== 32'h03122130) begin
            n_bad++;
            $display("FAIL skew_a_k3 got=%h want=03122130",
                     {fa[3][0], fa[3][1], fa[3][2], fa[3][3]});
        end
        n_vec++;
        if ({fb[3][0], fb[3][1], fb[3][2], fb[3][3]} !== 32'h8C898683) begin
            n_bad++;
            $display("FAIL skew_b_k3 got=%h want=8C898683",
                     {fb[3][0], fb[3][1], fb[3][2], fb[3][3]});
        end
        array_respond(5);
        recv_tx(1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 16; n++) begin
            ma[n]    = 8'h7F;
            mb[n]    = 8'h7F;
            exp_c[n] = 16'hFC04;
        end
        fill_exp_tx();
        run_op(1'b0, 1'b0);
    endtask

    task automatic test_tx_stall();
        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'(3 * n + 1);
            mb[n] = 8'(8'hF0 - n);
        end
        ref_matmul();
        fill_exp_tx();
        run_op(1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        bit saw_tx;
        saw_tx = 1'b0;
        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'(n);
            mb[n] = 8'(n);
        end
        send_bytes(32);
        capture_feed();
        for (int n = 1; n <= 63; n++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) saw_tx = 1'b1;
        end
        n_vec++;
        if ({busy, err} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_early got=%b want=10", {busy, err});
        end
        @(negedge clk);
        if (tx_valid !== 1'b0) saw_tx = 1'b1;
        n_vec++;
        if ({err, arr_rst, rx_ready, busy, saw_tx} !== 5'b11100) begin
            n_bad++;
            $display("FAIL timeout_state got=%b want=11100",
                     {err, arr_rst, rx_ready, busy, saw_tx});
        end
    endtask

    task automatic test_reset_mid_load();
        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'hA5;
            mb[n] = 8'h5A;
        end
        send_bytes(20);
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({err, rx_ready, arr_rst, busy} !== 4'b0110) begin
            n_bad++;
            $display("FAIL reset_mid got=%b want=0110", {err, rx_ready, arr_rst, busy});
        end
        reset = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'(7 * n);
            mb[n] = 8'(n) ^ 8'h5A;
        end
        ref_matmul();
        fill_exp_tx();
        run_op(1'b0, 1'b1);
        run_op(1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        arr_done = 1'b0;
        for (int n = 0; n < 16; n++) c[n] = 16'h0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_skew();
        test_saturate();
        test_tx_stall();
        test_timeout();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
